// File: rtl/svm_seq_mac_classifier_pkg.sv
// Shared state type, width helpers and saturating add for the sequential-MAC SVM classifier.
package svm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ARGMAX,
        S_DONE
    } svm_state_e;

    // Wide enough that neither an accumulator nor a product can overflow before clamping.
    localparam int SVM_WIDE_W = 64;
    typedef logic signed [SVM_WIDE_W-1:0] svm_wide_t;

    function automatic int svm_clog2w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int svm_prod_w(input int inW, input int wW);
        return inW + wW + 1;
    endfunction

    function automatic svm_wide_t sat_add(input svm_wide_t a, input svm_wide_t b, input int accW);
        svm_wide_t sum;
        svm_wide_t hi;
        svm_wide_t lo;
        sum = a + b;
        hi  = (svm_wide_t'(1) <<< (accW - 1)) - svm_wide_t'(1);
        lo  = -hi - svm_wide_t'(1);
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/svm_seq_mac_classifier_if.sv
// Feature-in / result-out valid-ready bundle of the sequential-MAC SVM classifier.
interface svm_seq_mac_classifier_if
    import svm_pkg::*;
#(
    parameter int N_FEAT  = 21,
    parameter int IN_W    = 4,
    parameter int N_CLASS = 1,
    parameter int ACC_W   = 14
);
    localparam int CLS_W = svm_clog2w(N_CLASS);

    logic                      in_valid;
    logic                      in_ready;
    logic [N_FEAT*IN_W-1:0]    in_feat;
    logic                      out_valid;
    logic                      out_ready;
    logic [CLS_W-1:0]          out_class;
    logic signed [ACC_W-1:0]   out_score;
    logic [N_CLASS*ACC_W-1:0]  out_scores;

    modport master (
        output in_valid, in_feat, out_ready,
        input  in_ready, out_valid, out_class, out_score, out_scores
    );

    modport slave (
        input  in_valid, in_feat, out_ready,
        output in_ready, out_valid, out_class, out_score, out_scores
    );

endinterface

// File: rtl/svm_seq_mac_classifier_mac_lane.sv
// One class accumulator: weight mux, signed product and wrapping or saturating add.
// Optional saturation is enabled with `define SVM_SEQ_SAT_EN.
module svm_mac_lane
    import svm_pkg::*;
#(
    parameter int N_FEAT = 21,
    parameter int IN_W   = 4,
    parameter int W_W    = 8,
    parameter int ACC_W  = 14,
    parameter int FIDX_W = svm_clog2w(N_FEAT),
    parameter logic [N_FEAT*W_W-1:0] LANE_WEIGHTS = '0,
    parameter logic [ACC_W-1:0]      INTERCEPT    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    en_i,
    input  logic [FIDX_W-1:0]       featIdx_i,
    input  logic [IN_W-1:0]         feat_i,
    output logic signed [ACC_W-1:0] acc_o
);
    localparam int PROD_W = svm_prod_w(IN_W, W_W);

    logic signed [W_W-1:0]    weight;
    logic signed [PROD_W-1:0] prod;
    svm_wide_t                sum;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Features are unsigned, so a zero MSB is prepended before the signed multiply.
    always_comb begin
        weight = LANE_WEIGHTS[featIdx_i*W_W +: W_W];
        prod   = PROD_W'($signed({1'b0, feat_i})) * PROD_W'(weight);
`ifdef SVM_SEQ_SAT_EN
        sum    = sat_add(svm_wide_t'(acc_q), svm_wide_t'(prod), ACC_W);
`else
        sum    = svm_wide_t'(acc_q) + svm_wide_t'(prod);
`endif
        acc_d  = acc_q;
        if (load_i) begin
            acc_d = INTERCEPT;
        end else if (en_i) begin
            acc_d = ACC_W'(sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/svm_seq_mac_classifier.sv
// Time-multiplexed linear SVM: N_CLASS lanes accumulate one feature per cycle, then a sequential argmax.
// Define SVM_SEQ_SAT_EN for saturating accumulation instead of two's-complement wrap.
module svm_seq_mac_classifier
    import svm_pkg::*;
#(
    parameter int N_FEAT  = 21,
    parameter int IN_W    = 4,
    parameter int W_W     = 8,
    parameter int N_CLASS = 1,
    parameter int ACC_W   = 14,
    parameter logic [N_CLASS*N_FEAT*W_W-1:0] WEIGHTS    = '0,
    parameter logic [N_CLASS*ACC_W-1:0]      INTERCEPTS = '0
) (
    input logic clk,
    input logic rst,
    svm_seq_mac_classifier_if.slave bus
);
    localparam int CLS_W  = svm_clog2w(N_CLASS);
    localparam int FIDX_W = svm_clog2w(N_FEAT);
    localparam int KIDX_W = CLS_W + 1;

    svm_state_e               state_q;
    logic                     inReady_q;
    logic                     outValid_q;
    logic [CLS_W-1:0]         outClass_q;
    logic signed [ACC_W-1:0]  outScore_q;
    logic [N_CLASS*ACC_W-1:0] outScores_q;
    logic [N_FEAT*IN_W-1:0]   feat_q;
    logic [FIDX_W-1:0]        fIdx_q;
    logic [KIDX_W-1:0]        kIdx_q;
    logic [CLS_W-1:0]         best_q;

    logic signed [ACC_W-1:0]  acc [N_CLASS];
    logic [N_CLASS*ACC_W-1:0] scoresFlat;
    logic [IN_W-1:0]          featSel;
    logic [CLS_W-1:0]         kSel;
    logic                     accept;
    logic                     laneEn;
    logic                     kGreater;

    assign accept  = (state_q == S_IDLE) && bus.in_valid && inReady_q;
    assign laneEn  = (state_q == S_MAC);
    assign featSel = feat_q[fIdx_q*IN_W +: IN_W];
    assign kSel    = kIdx_q[CLS_W-1:0];

    always_comb begin
        kGreater = 1'b0;
        if (kIdx_q < KIDX_W'(N_CLASS)) begin
            kGreater = acc[kSel] > acc[best_q];
        end
    end

    for (genvar c = 0; c < N_CLASS; c++) begin : g_lane
        svm_mac_lane #(
            .N_FEAT      (N_FEAT),
            .IN_W        (IN_W),
            .W_W         (W_W),
            .ACC_W       (ACC_W),
            .FIDX_W      (FIDX_W),
            .LANE_WEIGHTS(WEIGHTS[c*N_FEAT*W_W +: N_FEAT*W_W]),
            .INTERCEPT   (INTERCEPTS[c*ACC_W +: ACC_W])
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load_i   (accept),
            .en_i     (laneEn),
            .featIdx_i(fIdx_q),
            .feat_i   (featSel),
            .acc_o    (acc[c])
        );
        assign scoresFlat[c*ACC_W +: ACC_W] = acc[c];
    end

    // ARGMAX always ends with one extra cycle that registers the outputs, so a
    // single-class build passes through it too and keeps latency N_FEAT+N_CLASS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            inReady_q   <= 1'b1;
            outValid_q  <= 1'b0;
            outClass_q  <= '0;
            outScore_q  <= '0;
            outScores_q <= '0;
            feat_q      <= '0;
            fIdx_q      <= '0;
            kIdx_q      <= '0;
            best_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        feat_q    <= bus.in_feat;
                        fIdx_q    <= '0;
                        inReady_q <= 1'b0;
                        state_q   <= S_MAC;
                    end
                end
                S_MAC: begin
                    fIdx_q <= fIdx_q + FIDX_W'(1);
                    if (fIdx_q == FIDX_W'(N_FEAT - 1)) begin
                        best_q  <= '0;
                        kIdx_q  <= KIDX_W'(1);
                        state_q <= S_ARGMAX;
                    end
                end
                S_ARGMAX: begin
                    if (kIdx_q < KIDX_W'(N_CLASS)) begin
                        if (kGreater) begin
                            best_q <= kSel;
                        end
                        kIdx_q <= kIdx_q + KIDX_W'(1);
                    end else begin
                        outValid_q  <= 1'b1;
                        outClass_q  <= best_q;
                        outScore_q  <= acc[best_q];
                        outScores_q <= scoresFlat;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = inReady_q;
    assign bus.out_valid  = outValid_q;
    assign bus.out_class  = outClass_q;
    assign bus.out_score  = outScore_q;
    assign bus.out_scores = outScores_q;

endmodule

// File: tb/tb_svm_seq_mac_classifier.sv
// Self-checking bench: three classifier configurations against a plain-arithmetic reference model.
module tb_svm_seq_mac_classifier;
    import svm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Argmax config, regression config and narrow-accumulator overflow config.
    svm_seq_mac_classifier_if #(.N_FEAT(2), .IN_W(4), .N_CLASS(3), .ACC_W(14)) aIf ();
    svm_seq_mac_classifier_if #(.N_FEAT(3), .IN_W(4), .N_CLASS(1), .ACC_W(14)) rIf ();
    svm_seq_mac_classifier_if #(.N_FEAT(1), .IN_W(4), .N_CLASS(1), .ACC_W(8))  oIf ();

    svm_seq_mac_classifier #(
        .N_FEAT(2), .IN_W(4), .W_W(8), .N_CLASS(3), .ACC_W(14),
        .WEIGHTS({8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01}),
        .INTERCEPTS({14'h3FEC, 14'h0000, 14'h0000})
    ) dutA (.clk(clk), .rst(rst), .bus(aIf.slave));

    svm_seq_mac_classifier #(
        .N_FEAT(3), .IN_W(4), .W_W(8), .N_CLASS(1), .ACC_W(14),
        .WEIGHTS({8'h01, 8'hFD, 8'h02}),
        .INTERCEPTS(14'd5)
    ) dutR (.clk(clk), .rst(rst), .bus(rIf.slave));

    svm_seq_mac_classifier #(
        .N_FEAT(1), .IN_W(4), .W_W(8), .N_CLASS(1), .ACC_W(8),
        .WEIGHTS(8'h7F),
        .INTERCEPTS(8'h00)
    ) dutO (.clk(clk), .rst(rst), .bus(oIf.slave));

    int WA [3][2] = '{'{1, 0}, '{0, 1}, '{1, 1}};
    int BA [3]    = '{0, 0, -20};
    int WR [3]    = '{2, -3, 1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int wrapTo(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        return (m >= (1 << (w - 1))) ? m - (1 << w) : m;
    endfunction

    // Scores straight from the dot-product definition, then argmax with ties to the lowest index.
    task automatic refModel(input int sel, input int f[3], output int s[3], output int best);
        int nc;
        s = '{0, 0, 0};
        nc = (sel == 0) ? 3 : 1;
        case (sel)
            0: for (int c = 0; c < 3; c++) s[c] = wrapTo(BA[c] + WA[c][0]*f[0] + WA[c][1]*f[1], 14);
            1: s[0] = wrapTo(5 + WR[0]*f[0] + WR[1]*f[1] + WR[2]*f[2], 14);
            default: begin
                s[0] = 127 * f[0];
`ifdef SVM_SEQ_SAT_EN
                s[0] = (s[0] > 127) ? 127 : ((s[0] < -128) ? -128 : s[0]);
`else
                s[0] = wrapTo(s[0], 8);
`endif
            end
        endcase
        best = 0;
        for (int k = 1; k < nc; k++) if (s[k] > s[best]) best = k;
    endtask

    task automatic setIn(input int sel, input int f[3], input logic v);
        case (sel)
            0: begin aIf.in_feat = {4'(f[1]), 4'(f[0])}; aIf.in_valid = v; end
            1: begin rIf.in_feat = {4'(f[2]), 4'(f[1]), 4'(f[0])}; rIf.in_valid = v; end
            default: begin oIf.in_feat = 4'(f[0]); oIf.in_valid = v; end
        endcase
    endtask

    task automatic setOutReady(input int sel, input logic v);
        case (sel)
            0: aIf.out_ready = v;
            1: rIf.out_ready = v;
            default: oIf.out_ready = v;
        endcase
    endtask

    function automatic longint inReady(input int sel);
        return (sel == 0) ? longint'(aIf.in_ready) : (sel == 1) ? longint'(rIf.in_ready) : longint'(oIf.in_ready);
    endfunction

    function automatic longint outValid(input int sel);
        return (sel == 0) ? longint'(aIf.out_valid) : (sel == 1) ? longint'(rIf.out_valid) : longint'(oIf.out_valid);
    endfunction

    function automatic longint classOf(input int sel);
        return (sel == 0) ? longint'(aIf.out_class) : (sel == 1) ? longint'(rIf.out_class) : longint'(oIf.out_class);
    endfunction

    function automatic longint scoreOf(input int sel);
        return (sel == 0) ? longint'(aIf.out_score) : (sel == 1) ? longint'(rIf.out_score) : longint'(oIf.out_score);
    endfunction

    function automatic longint scoresOf(input int sel, input int k);
        logic signed [13:0] a;
        logic signed [13:0] r;
        logic signed [7:0]  o;
        a = aIf.out_scores[k*14 +: 14];
        r = rIf.out_scores;
        o = oIf.out_scores;
        return (sel == 0) ? longint'(a) : (sel == 1) ? longint'(r) : longint'(o);
    endfunction

    // Present a vector, wait for acceptance, scramble in_feat, then count cycles to out_valid.
    task automatic applyStimulus(input int sel, input int f[3], output int lat);
        int cyc;
        int junk[3];
        setIn(sel, f, 1'b1);
        cyc = 0;
        while (inReady(sel) != 1 && cyc < 100) begin tick(); cyc++; end
        checkOutput($sformatf("dut%0d.in_ready_pre", sel), inReady(sel), 1);
        tick();
        junk = '{int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15))};
        setIn(sel, junk, 1'b0);
        cyc = 0;
        while (outValid(sel) != 1 && cyc < 100) begin tick(); cyc++; end
        lat = cyc;
    endtask

    task automatic runCase(input int sel, input int f[3], input int hold, input string tag);
        int lat;
        int s[3];
        int best;
        int nc;
        nc = (sel == 0) ? 3 : 1;
        applyStimulus(sel, f, lat);
        checkOutput({tag, ".latency"}, lat, ((sel == 0) ? 2 : (sel == 1) ? 3 : 1) + nc);
        refModel(sel, f, s, best);
        for (int i = 0; i < hold; i++) tick();
        checkOutput({tag, ".out_valid"}, outValid(sel), 1);
        checkOutput({tag, ".in_ready_busy"}, inReady(sel), 0);
        checkOutput({tag, ".out_class"}, classOf(sel), best);
        checkOutput({tag, ".out_score"}, scoreOf(sel), s[best]);
        for (int k = 0; k < nc; k++) checkOutput($sformatf("%s.out_scores%0d", tag, k), scoresOf(sel, k), s[k]);
        setOutReady(sel, 1'b1);
        tick();
        setOutReady(sel, 1'b0);
        checkOutput({tag, ".out_valid_drop"}, outValid(sel), 0);
        checkOutput({tag, ".in_ready_rise"}, inReady(sel), 1);
    endtask

    initial begin
        int f[3];
        rst = 1'b1;
        for (int sel = 0; sel < 3; sel++) begin
            setIn(sel, '{0, 0, 0}, 1'b0);
            setOutReady(sel, 1'b0);
        end
        #1;
        for (int sel = 0; sel < 3; sel++) begin
            checkOutput($sformatf("reset.dut%0d.in_ready", sel), inReady(sel), 1);
            checkOutput($sformatf("reset.dut%0d.out_valid", sel), outValid(sel), 0);
            checkOutput($sformatf("reset.dut%0d.out_score", sel), scoreOf(sel), 0);
            checkOutput($sformatf("reset.dut%0d.out_class", sel), classOf(sel), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();

        runCase(1, '{15, 4, 7}, 0, "regression");
        checkOutput("regression.score30", scoreOf(1), 30);
        runCase(0, '{9, 9, 0}, 0, "tie");
        runCase(0, '{3, 10, 0}, 5, "win_backpressure");
        runCase(2, '{15, 0, 0}, 0, "overflow");
`ifdef SVM_SEQ_SAT_EN
        checkOutput("overflow.sat127", scoreOf(2), 127);
`else
        checkOutput("overflow.wrap113", scoreOf(2), 113);
`endif
        runCase(0, '{12, 1, 0}, 0, "b2b_first");
        runCase(0, '{0, 14, 0}, 0, "b2b_second");

        // Reset two cycles into MAC must clear everything at once.
        setIn(0, '{5, 7, 0}, 1'b1);
        tick();
        setIn(0, '{0, 0, 0}, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midreset.out_valid", outValid(0), 0);
        checkOutput("midreset.in_ready", inReady(0), 1);
        checkOutput("midreset.out_score", scoreOf(0), 0);
        checkOutput("midreset.out_scores1", scoresOf(0, 1), 0);
        #2;
        rst = 1'b0;
        tick();
        runCase(0, '{2, 13, 0}, 0, "post_reset");

        for (int i = 0; i < 6; i++) begin
            f = '{int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0};
            runCase(0, f, int'($urandom_range(0, 2)), $sformatf("randA%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            f = '{int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15))};
            runCase(1, f, int'($urandom_range(0, 2)), $sformatf("randR%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            f = '{int'($urandom_range(0, 15)), 0, 0};
            runCase(2, f, 0, $sformatf("randO%0d", i));
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
